// File: rtl/ble_packet_receiver.sv
// ble_packet_receiver: BLE access-address search, header/payload deframing and CRC-24 check; BLE_RX_DEWHITEN_EN adds the channel dewhitener
module ble_packet_receiver #(
  parameter logic [31:0] ACCESS_ADDR = 32'h8E89BED6,
  parameter logic [7:0]  MAX_LEN     = 8'd37,
  parameter logic [23:0] CRC_INIT    = 24'h555555
`ifdef BLE_RX_DEWHITEN_EN
  ,
  parameter logic [5:0]  CHANNEL     = 6'd37
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxEn,
  input  logic       symValid,
  input  logic       symVal,
  output logic       pktStart,
  output logic [7:0] byteOut,
  output logic       byteValid,
  output logic       pktDone,
  output logic       crcOk,
  output logic       lenErr
);
  typedef enum logic [1:0] {SEARCH, HEADER, PAYLOAD, CRC} state_t;
  state_t state_q, state_d;
  logic [31:0] aa_q, aa_d, aa_shift;
  logic [23:0] crc_q, crc_d, crc_step;
  logic [23:0] rx_crc_q, rx_crc_d, rx_shift;
  logic [7:0] byte_q, byte_d, shift;
  logic [7:0] len_q, len_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0] byte_out_q, byte_out_d;
  logic byte_valid_q, byte_valid_d;
  logic pkt_start_q, pkt_start_d;
  logic pkt_done_q, pkt_done_d;
  logic crc_ok_q, crc_ok_d;
  logic len_err_q, len_err_d;
  logic d;
`ifdef BLE_RX_DEWHITEN_EN
  logic [6:0] w_q, w_d, w_next;
  always_comb begin
    d = symVal ^ w_q[6];
    w_next = {w_q[5:4], w_q[3] ^ w_q[6], w_q[2:0], w_q[6]};
  end
  always_ff @(posedge clk) w_q <= rst ? 7'd0 : w_d;
`else
  always_comb d = symVal;
`endif
  always_comb begin
    aa_shift = {symVal, aa_q[31:1]};
    crc_step = {crc_q[22:0], 1'b0} ^ ((crc_q[23] ^ d) ? 24'h00065B : 24'h0);
    shift = {d, byte_q[7:1]};
    rx_shift = {rx_crc_q[22:0], d};
    state_d = state_q;
    aa_d = aa_q;
    crc_d = crc_q;
    rx_crc_d = rx_crc_q;
    byte_d = byte_q;
    len_d = len_q;
    cnt_d = cnt_q;
    byte_out_d = byte_out_q;
    byte_valid_d = 1'b0;
    pkt_start_d = 1'b0;
    pkt_done_d = 1'b0;
    crc_ok_d = 1'b0;
    len_err_d = 1'b0;
`ifdef BLE_RX_DEWHITEN_EN
    w_d = w_q;
`endif
    if (!rxEn) begin
      state_d = SEARCH;
      aa_d = '0;
    end else if (symValid) begin
      case (state_q)
        SEARCH: begin
          aa_d = aa_shift;
          if (aa_shift == ACCESS_ADDR) begin
            state_d = HEADER;
            pkt_start_d = 1'b1;
            crc_d = CRC_INIT;
            cnt_d = '0;
            byte_d = '0;
`ifdef BLE_RX_DEWHITEN_EN
            w_d = {1'b1, CHANNEL};
`endif
          end
        end
        HEADER, PAYLOAD: begin
          crc_d = crc_step;
          byte_d = shift;
          cnt_d = cnt_q + 11'd1;
`ifdef BLE_RX_DEWHITEN_EN
          w_d = w_next;
`endif
          if (cnt_q[2:0] == 3'd7) begin
            byte_out_d = shift;
            byte_valid_d = 1'b1;
          end
          if (state_q == HEADER && cnt_q == 11'd15) begin
            len_d = shift;
            cnt_d = '0;
            if (shift > MAX_LEN) begin
              len_err_d = 1'b1;
              state_d = SEARCH;
              aa_d = '0;
            end else begin
              state_d = (shift == 8'd0) ? CRC : PAYLOAD;
            end
          end
          if (state_q == PAYLOAD && cnt_q == {len_q - 8'd1, 3'b111}) begin
            state_d = CRC;
            cnt_d = '0;
          end
        end
        default: begin
          rx_crc_d = rx_shift;
          cnt_d = cnt_q + 11'd1;
`ifdef BLE_RX_DEWHITEN_EN
          w_d = w_next;
`endif
          if (cnt_q == 11'd23) begin
            pkt_done_d = 1'b1;
            crc_ok_d = (rx_shift == crc_q);
            state_d = SEARCH;
            aa_d = '0;
            cnt_d = '0;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEARCH;
      aa_q <= '0;
      crc_q <= '0;
      rx_crc_q <= '0;
      byte_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      byte_out_q <= '0;
      byte_valid_q <= 1'b0;
      pkt_start_q <= 1'b0;
      pkt_done_q <= 1'b0;
      crc_ok_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      aa_q <= aa_d;
      crc_q <= crc_d;
      rx_crc_q <= rx_crc_d;
      byte_q <= byte_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      byte_out_q <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      pkt_start_q <= pkt_start_d;
      pkt_done_q <= pkt_done_d;
      crc_ok_q <= crc_ok_d;
      len_err_q <= len_err_d;
    end
  end
  assign pktStart = pkt_start_q;
  assign byteOut = byte_out_q;
  assign byteValid = byte_valid_q;
  assign pktDone = pkt_done_q;
  assign crcOk = crc_ok_q;
  assign lenErr = len_err_q;
endmodule

// File: tb/tb_ble_packet_receiver.sv
// tb_ble_packet_receiver: directed frames against ble_packet_receiver; frames are whitened when BLE_RX_DEWHITEN_EN is defined
module tb_ble_packet_receiver;
  localparam logic [31:0] AA = 32'h8E89BED6;
  localparam logic [23:0] CINIT = 24'h555555;
`ifdef BLE_RX_DEWHITEN_EN
  localparam bit WH = 1'b1;
`else
  localparam bit WH = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1, rxEn = 1'b1, symValid = 1'b0, symVal = 1'b0;
  logic pktStart, byteValid, pktDone, crcOk, lenErr;
  logic [7:0] byteOut;
  always #5 clk = ~clk;
  ble_packet_receiver dut (
    .clk(clk), .rst(rst), .rxEn(rxEn), .symValid(symValid), .symVal(symVal),
    .pktStart(pktStart), .byteOut(byteOut), .byteValid(byteValid),
    .pktDone(pktDone), .crcOk(crcOk), .lenErr(lenErr)
  );
  int total = 0, bad = 0;
  int n_start = 0, n_done = 0, n_ok = 0, n_lenerr = 0, n_lenerr_nobyte = 0, n_okleak = 0;
  int s0, d0, k0, l0, g0;
  logic last_ok = 1'b0;
  logic [7:0] got[$];
  logic [7:0] pkt[$];
  logic [6:0] w;
  int gap = 0;
  always @(negedge clk) begin
    if (pktStart) n_start++;
    if (byteValid) got.push_back(byteOut);
    if (pktDone) begin
      n_done++;
      last_ok = crcOk;
      if (crcOk) n_ok++;
    end
    if (lenErr) begin
      n_lenerr++;
      if (!byteValid) n_lenerr_nobyte++;
    end
    if (crcOk && !pktDone) n_okleak++;
  end
  function automatic logic [23:0] model_crc();
    logic [23:0] c = CINIT;
    foreach (pkt[i])
      for (int j = 0; j < 8; j++)
        c = {c[22:0], 1'b0} ^ ((c[23] ^ pkt[i][j]) ? 24'h00065B : 24'h0);
    return c;
  endfunction
  task automatic mark();
    s0 = n_start; d0 = n_done; k0 = n_ok; l0 = n_lenerr; g0 = got.size();
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic send_bit(input logic b);
    symVal = b;
    symValid = 1'b1;
    @(posedge clk); #1;
    symValid = 1'b0;
    symVal = 1'b0;
    idle(gap);
  endtask
  task automatic send_wbit(input logic b);
    logic t;
    t = WH ? b ^ w[6] : b;
    w = {w[5:4], w[3] ^ w[6], w[2:0], w[6]};
    send_bit(t);
  endtask
  task automatic send_head(input logic [31:0] addr);
    logic [7:0] pre = 8'hAA;
    for (int i = 0; i < 8; i++) send_bit(pre[i]);
    for (int i = 0; i < 32; i++) send_bit(addr[i]);
    w = {1'b1, 6'd37};
  endtask
  task automatic send_pkt_bytes(input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++) send_wbit(pkt[i][j]);
  endtask
  task automatic send_frame(input logic [31:0] addr, input logic [23:0] flip);
    logic [23:0] c;
    c = model_crc() ^ flip;
    send_head(addr);
    send_pkt_bytes(pkt.size());
    for (int i = 23; i >= 0; i--) send_wbit(c[i]);
    idle(2);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    total++; if ({pktStart, byteValid, pktDone, crcOk, lenErr} !== 5'b0) begin bad++; $display("FAIL reset_pulses got=%b want=00000", {pktStart, byteValid, pktDone, crcOk, lenErr}); end
    total++; if (byteOut !== 8'h00) begin bad++; $display("FAIL reset_byteout got=%h want=00", byteOut); end
    rst = 1'b0;
    idle(2);
  endtask
  task automatic test_good();
    pkt = '{8'h40, 8'h03, 8'hA1, 8'hB2, 8'hC3};
    mark();
    send_frame(AA, 24'h0);
    total++; if (n_start - s0 !== 1) begin bad++; $display("FAIL good_start got=%0d want=1", n_start - s0); end
    total++; if (got.size() - g0 !== 5) begin bad++; $display("FAIL good_nbytes got=%0d want=5", got.size() - g0); end
    for (int i = 0; i < 5 && g0 + i < got.size(); i++) begin
      total++; if (got[g0 + i] !== pkt[i]) begin bad++; $display("FAIL good_byte%0d got=%h want=%h", i, got[g0 + i], pkt[i]); end
    end
    total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL good_done got=%0d want=1", n_done - d0); end
    total++; if (last_ok !== 1'b1) begin bad++; $display("FAIL good_crcok got=%b want=1", last_ok); end
  endtask
  task automatic test_bad_crc();
    pkt = '{8'h40, 8'h03, 8'hA1, 8'hB2, 8'hC3};
    mark();
    send_frame(AA, 24'h000020);
    total++; if (got.size() - g0 !== 5) begin bad++; $display("FAIL badcrc_nbytes got=%0d want=5", got.size() - g0); end
    for (int i = 0; i < 5 && g0 + i < got.size(); i++) begin
      total++; if (got[g0 + i] !== pkt[i]) begin bad++; $display("FAIL badcrc_byte%0d got=%h want=%h", i, got[g0 + i], pkt[i]); end
    end
    total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL badcrc_done got=%0d want=1", n_done - d0); end
    total++; if (last_ok !== 1'b0) begin bad++; $display("FAIL badcrc_crcok got=%b want=0", last_ok); end
  endtask
  task automatic test_len_err();
    pkt = '{8'h40, 8'h30};
    mark();
    send_head(AA);
    send_pkt_bytes(2);
    idle(3);
    total++; if (got.size() - g0 !== 2) begin bad++; $display("FAIL lenerr_nbytes got=%0d want=2", got.size() - g0); end
    for (int i = 0; i < 2 && g0 + i < got.size(); i++) begin
      total++; if (got[g0 + i] !== pkt[i]) begin bad++; $display("FAIL lenerr_byte%0d got=%h want=%h", i, got[g0 + i], pkt[i]); end
    end
    total++; if (n_lenerr - l0 !== 1) begin bad++; $display("FAIL lenerr_pulse got=%0d want=1", n_lenerr - l0); end
    total++; if (n_lenerr_nobyte !== 0) begin bad++; $display("FAIL lenerr_align got=%0d want=0", n_lenerr_nobyte); end
    total++; if (n_done - d0 !== 0) begin bad++; $display("FAIL lenerr_done got=%0d want=0", n_done - d0); end
    pkt = '{8'h40, 8'h03, 8'hA1, 8'hB2, 8'hC3};
    mark();
    send_frame(AA, 24'h0);
    total++; if (n_ok - k0 !== 1) begin bad++; $display("FAIL lenerr_next_ok got=%0d want=1", n_ok - k0); end
  endtask
  task automatic test_bad_aa();
    pkt = '{8'h40, 8'h03, 8'hA1, 8'hB2, 8'hC3};
    mark();
    send_frame(AA ^ 32'h0002_0000, 24'h0);
    total++; if (n_start - s0 !== 0) begin bad++; $display("FAIL badaa_start got=%0d want=0", n_start - s0); end
    total++; if (got.size() - g0 !== 0) begin bad++; $display("FAIL badaa_bytes got=%0d want=0", got.size() - g0); end
    total++; if (n_done - d0 !== 0) begin bad++; $display("FAIL badaa_done got=%0d want=0", n_done - d0); end
  endtask
  task automatic test_abort();
    pkt = '{8'h40, 8'h03, 8'hA1, 8'hB2, 8'hC3};
    mark();
    send_head(AA);
    send_pkt_bytes(3);
    rxEn = 1'b0;
    idle(2);
    rxEn = 1'b1;
    send_frame(AA, 24'h0);
    total++; if (n_start - s0 !== 2) begin bad++; $display("FAIL rxen_start got=%0d want=2", n_start - s0); end
    total++; if (got.size() - g0 !== 8) begin bad++; $display("FAIL rxen_nbytes got=%0d want=8", got.size() - g0); end
    total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL rxen_done got=%0d want=1", n_done - d0); end
    total++; if (n_ok - k0 !== 1) begin bad++; $display("FAIL rxen_ok got=%0d want=1", n_ok - k0); end
    mark();
    send_head(AA);
    send_pkt_bytes(2);
    for (int j = 0; j < 7; j++) send_wbit(pkt[2][j]);
    symVal = pkt[2][7] ^ (WH ? w[6] : 1'b0);
    symValid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    symValid = 1'b0;
    rst = 1'b0;
    total++; if ({pktStart, byteValid, pktDone, crcOk, lenErr} !== 5'b0) begin bad++; $display("FAIL rst_pulses got=%b want=00000", {pktStart, byteValid, pktDone, crcOk, lenErr}); end
    total++; if (byteOut !== 8'h00) begin bad++; $display("FAIL rst_byteout got=%h want=00", byteOut); end
    send_frame(AA, 24'h0);
    total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL rst_done got=%0d want=1", n_done - d0); end
    total++; if (n_ok - k0 !== 1) begin bad++; $display("FAIL rst_ok got=%0d want=1", n_ok - k0); end
  endtask
  task automatic test_len_bounds();
    pkt = '{8'h40, 8'h00};
    mark();
    send_frame(AA, 24'h0);
    total++; if (got.size() - g0 !== 2) begin bad++; $display("FAIL len0_nbytes got=%0d want=2", got.size() - g0); end
    total++; if (n_ok - k0 !== 1) begin bad++; $display("FAIL len0_ok got=%0d want=1", n_ok - k0); end
    pkt = '{8'h40, 8'd37};
    for (int i = 0; i < 37; i++) pkt.push_back(8'(i * 7 + 1));
    mark();
    send_frame(AA, 24'h0);
    total++; if (got.size() - g0 !== 39) begin bad++; $display("FAIL len37_nbytes got=%0d want=39", got.size() - g0); end
    for (int i = 0; i < 39 && g0 + i < got.size(); i++) begin
      total++; if (got[g0 + i] !== pkt[i]) begin bad++; $display("FAIL len37_byte%0d got=%h want=%h", i, got[g0 + i], pkt[i]); end
    end
    total++; if (n_ok - k0 !== 1) begin bad++; $display("FAIL len37_ok got=%0d want=1", n_ok - k0); end
    total++; if (n_lenerr - l0 !== 0) begin bad++; $display("FAIL len37_lenerr got=%0d want=0", n_lenerr - l0); end
    pkt = '{8'h40, 8'd38};
    mark();
    send_head(AA);
    send_pkt_bytes(2);
    idle(2);
    total++; if (n_lenerr - l0 !== 1) begin bad++; $display("FAIL len38_lenerr got=%0d want=1", n_lenerr - l0); end
  endtask
  task automatic test_back_to_back();
    gap = 1;
    pkt = '{8'h02, 8'h02, 8'h5A, 8'hA5};
    mark();
    send_frame(AA, 24'h0);
    gap = 0;
    pkt = '{8'h01, 8'h01, 8'hFF};
    send_frame(AA, 24'h0);
    total++; if (n_done - d0 !== 2) begin bad++; $display("FAIL b2b_done got=%0d want=2", n_done - d0); end
    total++; if (n_ok - k0 !== 2) begin bad++; $display("FAIL b2b_ok got=%0d want=2", n_ok - k0); end
    total++; if (got.size() - g0 !== 7) begin bad++; $display("FAIL b2b_nbytes got=%0d want=7", got.size() - g0); end
    if (got.size() - g0 == 7) begin
      total++; if (got[g0 + 2] !== 8'h5A) begin bad++; $display("FAIL b2b_byte2 got=%h want=5a", got[g0 + 2]); end
      total++; if (got[g0 + 6] !== 8'hFF) begin bad++; $display("FAIL b2b_byte6 got=%h want=ff", got[g0 + 6]); end
    end
    total++; if (n_okleak !== 0) begin bad++; $display("FAIL crcok_leak got=%0d want=0", n_okleak); end
  endtask
  initial begin
    test_reset();
    test_good();
    test_bad_crc();
    test_len_err();
    test_bad_aa();
    test_abort();
    test_len_bounds();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
